// File: rtl/sys_seq_pkg.sv
// sys_seq_pkg: shared state encoding, LED codes and default timing for the bring-up sequencer
package sys_seq_pkg;
  typedef enum logic [2:0] {IDLE, PWRUP, KICK, SETUP_WAIT, SETTLE, DISPLAY, FAULT} state_e;
  localparam logic [5:0] LED_IDLE       = 6'b000_001;
  localparam logic [5:0] LED_PWRUP      = 6'b000_011;
  localparam logic [5:0] LED_KICK       = 6'b000_111;
  localparam logic [5:0] LED_SETUP_WAIT = 6'b001_111;
  localparam logic [5:0] LED_SETTLE     = 6'b101_010;
  localparam logic [5:0] LED_DISPLAY    = 6'b111_111;
  localparam logic [5:0] LED_FAULT      = 6'b100_001;
  localparam int unsigned DEF_POWERUP_CYC       = 50;
  localparam int unsigned DEF_SETUP_TIMEOUT_CYC = 2_500_000;
  localparam int unsigned DEF_SETTLE_CYC        = 7_500_000;
  localparam int unsigned DEF_MAX_RETRIES       = 3;
  function automatic logic [5:0] led_code(state_e s);
    case (s)
      IDLE:       return LED_IDLE;
      PWRUP:      return LED_PWRUP;
      KICK:       return LED_KICK;
      SETUP_WAIT: return LED_SETUP_WAIT;
      SETTLE:     return LED_SETTLE;
      DISPLAY:    return LED_DISPLAY;
      FAULT:      return LED_FAULT;
      default:    return 6'b000_000;
    endcase
  endfunction
endpackage

// File: rtl/sys_seq_timer.sv
// sys_seq_timer: loadable down-counter that saturates at zero
module sys_seq_timer #(
  parameter int unsigned TIMER_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic [TIMER_W-1:0] value,
  output logic               zero
);
  logic [TIMER_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (cnt_q == '0 ? cnt_q : cnt_q - TIMER_W'(1));
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign value = cnt_q;
  assign zero  = cnt_q == '0;
endmodule

// File: rtl/system_sequencer_gen2.sv
// system_sequencer_gen2: PLL-lock to camera-setup to display bring-up FSM with retries and fault handling
module system_sequencer_gen2
  import sys_seq_pkg::*;
#(
  parameter int unsigned TIMER_W           = 32,
  parameter int unsigned POWERUP_CYC       = DEF_POWERUP_CYC,
  parameter int unsigned SETUP_TIMEOUT_CYC = DEF_SETUP_TIMEOUT_CYC,
  parameter int unsigned SETTLE_CYC        = DEF_SETTLE_CYC,
  parameter int unsigned MAX_RETRIES       = DEF_MAX_RETRIES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       locked,
  input  logic       setup_done,
  input  logic       setup_error,
  input  logic       testmode,
  input  logic       restart,
  output logic       start_setup,
  output logic       start_capture,
  output logic       ready_display,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [5:0] control_state
);
  localparam logic [3:0] MAX_R = 4'(MAX_RETRIES);
  state_e state_q, state_d;
  logic [3:0] retry_q, retry_d;
  logic fault_q, fault_d;
  logic start_setup_q, start_capture_q, ready_display_q;
  logic [5:0] control_state_q;
  logic tmr_load, tmr_zero;
  logic [TIMER_W-1:0] tmr_val, tmr_value;
  sys_seq_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .load_val(tmr_val),
    .value   (tmr_value),
    .zero    (tmr_zero)
  );
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    if (restart || (!locked && state_q != IDLE)) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:       if (locked) state_d = testmode ? DISPLAY : PWRUP;
        PWRUP:      if (tmr_zero) state_d = KICK;
        KICK:       state_d = SETUP_WAIT;
        SETUP_WAIT: begin
          if (setup_done || testmode) state_d = SETTLE;
          else if (setup_error || tmr_zero) begin
            state_d = retry_q < MAX_R ? KICK : FAULT;
            retry_d = retry_q < MAX_R ? retry_q + 4'd1 : retry_q;
          end
        end
        SETTLE:     if (tmr_zero) state_d = DISPLAY;
        DISPLAY:    state_d = DISPLAY;
        FAULT:      state_d = FAULT;
        default:    state_d = IDLE;
      endcase
    end
    retry_d  = state_d == IDLE ? 4'd0 : retry_d;
    fault_d  = restart ? 1'b0 : (state_d == FAULT || fault_q);
    // Timer is loaded on entry; a state exits on the cycle its count reaches zero.
    tmr_load = state_d != state_q;
    tmr_val  = state_d == PWRUP      ? TIMER_W'(POWERUP_CYC - 1) :
               state_d == SETUP_WAIT ? TIMER_W'(SETUP_TIMEOUT_CYC - 1) :
               state_d == SETTLE     ? TIMER_W'(SETTLE_CYC - 1) : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      retry_q         <= '0;
      fault_q         <= 1'b0;
      start_setup_q   <= 1'b0;
      start_capture_q <= 1'b0;
      ready_display_q <= 1'b0;
      control_state_q <= '0;
    end else begin
      state_q         <= state_d;
      retry_q         <= retry_d;
      fault_q         <= fault_d;
      start_setup_q   <= state_d == KICK;
      start_capture_q <= state_d == DISPLAY;
      ready_display_q <= state_d == DISPLAY;
      control_state_q <= led_code(state_d);
    end
  end
  assign start_setup   = start_setup_q;
  assign start_capture = start_capture_q;
  assign ready_display = ready_display_q;
  assign fault         = fault_q;
  assign retry_count   = retry_q;
  assign control_state = control_state_q;
endmodule

// File: tb/tb_system_sequencer_gen2.sv
// tb_system_sequencer_gen2: directed bench with a phase/age reference model checked every cycle
module tb_system_sequencer_gen2;
  localparam int POW = 4, TO = 8, SET = 5, MAXR = 2;
  logic clk = 1'b0, reset = 1'b1, locked = 1'b0, setup_done = 1'b0, setup_error = 1'b0;
  logic testmode = 1'b0, restart = 1'b0;
  logic start_setup, start_capture, ready_display, fault;
  logic [3:0] retry_count;
  logic [5:0] control_state;
  int tests = 0, fails = 0;
  system_sequencer_gen2 #(
    .TIMER_W(8), .POWERUP_CYC(POW), .SETUP_TIMEOUT_CYC(TO), .SETTLE_CYC(SET), .MAX_RETRIES(MAXR)
  ) dut (
    .clk(clk), .reset(reset), .locked(locked), .setup_done(setup_done), .setup_error(setup_error),
    .testmode(testmode), .restart(restart), .start_setup(start_setup), .start_capture(start_capture),
    .ready_display(ready_display), .fault(fault), .retry_count(retry_count), .control_state(control_state)
  );
  always #5 clk = ~clk;
  // Phases: 0 idle, 1 power-up, 2 kick, 3 setup wait, 4 settle, 5 display, 6 fault.
  logic [5:0] led_tab [7] = '{6'b000001, 6'b000011, 6'b000111, 6'b001111, 6'b101010, 6'b111111, 6'b100001};
  int m_ph = 0, m_age = 0, m_retry = 0;
  bit m_fault = 0, m_zero = 1, prev_ss = 0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_update();
    int np;
    if (reset) begin
      m_ph = 0; m_age = 0; m_retry = 0; m_fault = 0; m_zero = 1;
      return;
    end
    np = m_ph;
    if (restart || (!locked && m_ph != 0)) np = 0;
    else if (m_ph == 0 && locked) np = testmode ? 5 : 1;
    else if (m_ph == 1 && m_age == POW) np = 2;
    else if (m_ph == 2) np = 3;
    else if (m_ph == 3 && (setup_done || testmode)) np = 4;
    else if (m_ph == 3 && (setup_error || m_age == TO)) begin
      if (m_retry < MAXR) begin m_retry++; np = 2; end
      else np = 6;
    end
    else if (m_ph == 4 && m_age == SET) np = 5;
    if (np == 0) m_retry = 0;
    m_fault = restart ? 0 : (np == 6 || m_fault);
    m_age = np != m_ph ? 1 : m_age + 1;
    m_ph = np;
    m_zero = 0;
  endtask
  task automatic step();
    logic [13:0] exp_v;
    @(posedge clk);
    model_update();
    @(negedge clk);
    exp_v = m_zero ? 14'd0 : {m_ph == 2, m_ph == 5, m_ph == 5, m_fault, 4'(m_retry), led_tab[m_ph]};
    chk("outputs", {start_setup, start_capture, ready_display, fault, retry_count, control_state}, exp_v);
    chk("ss_rules", {start_setup & prev_ss, start_setup & ~locked}, 0);
    prev_ss = start_setup;
  endtask
  task automatic wait_sig(string nm, int which, int exp_n);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(which == 0 ? start_setup : which == 1 ? start_capture : fault) && n < 40);
    chk(nm, n, exp_n);
  endtask
  task automatic do_reset();
    reset = 1'b1; locked = 1'b0; testmode = 1'b0; restart = 1'b0; setup_done = 1'b0; setup_error = 1'b0;
    step(); step();
  endtask
  initial begin
    do_reset();
    chk("reset_ctrl", control_state, 6'b000000);
    chk("reset_retry_fault", {retry_count, fault, start_setup}, 0);
    // Normal path
    reset = 1'b0; locked = 1'b1;
    wait_sig("normal_kick_delay", 0, 5);
    step(); step(); step();
    setup_done = 1'b1; step(); setup_done = 1'b0;
    chk("normal_settle_led", control_state, 6'b101010);
    wait_sig("normal_settle_len", 1, 5);
    chk("normal_display", {start_capture, ready_display, control_state}, 8'b11_111111);
    chk("model_display_phase", m_ph, 5);
    // Lock loss in display, then full rerun with an error then success
    locked = 1'b0; step();
    chk("lockloss_disp", {start_capture, ready_display, retry_count, control_state}, {6'b0, 6'b000001});
    locked = 1'b1;
    wait_sig("relock_kick_delay", 0, 5);
    setup_error = 1'b1; step(); step(); setup_error = 1'b0;
    chk("err_retry_kick", {start_setup, retry_count}, {1'b1, 4'd1});
    step();
    setup_done = 1'b1; step(); setup_done = 1'b0;
    chk("err_then_ok_settle", {fault, retry_count, control_state}, {1'b0, 4'd1, 6'b101010});
    wait_sig("err_then_ok_display", 1, 5);
    chk("err_then_ok_final", {fault, retry_count}, {1'b0, 4'd1});
    // Lock loss during settle with a nonzero retry count
    locked = 1'b0; step(); locked = 1'b1;
    wait_sig("rerun_kick_delay", 0, 5);
    setup_error = 1'b1; step(); step(); setup_error = 1'b0;
    step(); setup_done = 1'b1; step(); setup_done = 1'b0; step();
    chk("pre_lockloss_settle", {retry_count, control_state}, {4'd1, 6'b101010});
    locked = 1'b0; step();
    chk("lockloss_settle", {start_capture, retry_count, control_state}, {1'b0, 4'd0, 6'b000001});
    // Testmode
    do_reset();
    reset = 1'b0; locked = 1'b1; testmode = 1'b1;
    step();
    chk("testmode_display", {start_setup, start_capture, ready_display, control_state}, {3'b011, 6'b111111});
    step(); step();
    // Timeouts to fault
    do_reset();
    reset = 1'b0; locked = 1'b1;
    wait_sig("to_kick1", 0, 5);
    wait_sig("to_kick2", 0, 9);
    chk("to_retry1", retry_count, 1);
    wait_sig("to_kick3", 0, 9);
    chk("to_retry2", retry_count, 2);
    wait_sig("to_fault", 2, 9);
    chk("to_fault_state", {fault, retry_count, control_state}, {1'b1, 4'd2, 6'b100001});
    chk("model_fault_phase", m_ph, 6);
    step(); step();
    // Restart from fault
    restart = 1'b1; step(); restart = 1'b0;
    chk("restart_clears", {fault, retry_count, control_state}, {1'b0, 4'd0, 6'b000001});
    wait_sig("restart_kick_delay", 0, 5);
    step();
    restart = 1'b1; setup_done = 1'b1; step(); restart = 1'b0; setup_done = 1'b0;
    chk("restart_beats_done", control_state, 6'b000001);
    // Fault is held across lock loss
    wait_sig("f2_kick1", 0, 5);
    wait_sig("f2_kick2", 0, 9);
    wait_sig("f2_kick3", 0, 9);
    wait_sig("f2_fault", 2, 9);
    locked = 1'b0; step();
    chk("lockloss_holds_fault", {fault, retry_count, control_state}, {1'b1, 4'd0, 6'b000001});
    restart = 1'b1; step(); restart = 1'b0;
    chk("restart_clears_fault", fault, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
